// File: rtl/serial_tx_shift.sv
// Parallel-in/serial-out transmitter for the FP adder serial interface.
// A word is captured on an accepted load and presented LSB-first, one bit
// per downstream read strobe, followed by a single-cycle end-of-frame pulse.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   parallel_in  word to transmit, sampled only on an accepted load
//   load_in      load strobe, accepted only while idle
//   rd_in        downstream bit-consume strobe
//   en_in        output enable / shift freeze
//   serial_out   current frame bit (LSB first)
//   valid_out    serial_out carries a live frame bit
//   busy_out     frame in progress
//   done_out     one-cycle pulse after the last bit is consumed
module serial_tx_shift #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_in,
    input  logic             rd_in,
    input  logic             en_in,
    output logic             serial_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // State, shift register and bit counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            count <= count_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                // A simultaneous rd_in is irrelevant here: nothing is in flight
                if (load_in) begin
                    shreg_nxt = parallel_in;
                    count_nxt = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rd_in && en_in) begin
                    if (count == LAST_BIT) begin
                        // Counter parks at the last index; no wrap inside a frame
                        state_nxt = ST_DONE;
                    end else begin
                        shreg_nxt = shreg >> 1;
                        count_nxt = count + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; en_in gates the live bit
    always_comb begin
        serial_out = (state == ST_SHIFT) & shreg[0] & en_in;
        valid_out  = (state == ST_SHIFT) & en_in;
        busy_out   = (state != ST_IDLE);
        done_out   = (state == ST_DONE);
    end

endmodule

// File: tb/tb_serial_tx_shift.sv
// Directed bench for serial_tx_shift: a table-driven basic frame followed by
// hand-written multi-cycle sequences for gaps, loads while busy, freeze,
// asynchronous reset and back-to-back frames.
module tb_serial_tx_shift;

    logic        clk_in;
    logic        rst_n_in;
    logic [15:0] parallel_in;
    logic        load_in;
    logic        rd_in;
    logic        en_in;
    logic        serial_out;
    logic        valid_out;
    logic        busy_out;
    logic        done_out;

    serial_tx_shift #(.WIDTH(16)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .parallel_in (parallel_in),
        .load_in     (load_in),
        .rd_in       (rd_in),
        .en_in       (en_in),
        .serial_out  (serial_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .done_out    (done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        ld;
        logic        rd;
        logic        en;
        logic [15:0] d;
        logic        ser;
        logic        val;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [19];
    int   basic_seq [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_no = 0;
    logic s_ser, s_val, s_busy, s_done;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic ser, input logic val,
                        input logic busy, input logic done);
        chk({name, ".serial"}, int'(s_ser),  int'(ser));
        chk({name, ".valid"},  int'(s_val),  int'(val));
        chk({name, ".busy"},   int'(s_busy), int'(busy));
        chk({name, ".done"},   int'(s_done), int'(done));
    endtask

    // Drive one cycle of inputs, sample outputs on the falling edge
    task automatic cyc(input logic ld, input logic rd, input logic en, input logic [15:0] d);
        load_in     = ld;
        rd_in       = rd;
        en_in       = en;
        parallel_in = d;
        @(negedge clk_in);
        s_ser  = serial_out;
        s_val  = valid_out;
        s_busy = busy_out;
        s_done = done_out;
        @(posedge clk_in);
        #1;
        cyc_no++;
    endtask

    int done_a;
    int done_b;
    logic [15:0] w;

    initial begin
        rst_n_in    = 1'b0;
        load_in     = 1'b0;
        rd_in       = 1'b0;
        en_in       = 1'b1;
        parallel_in = 16'h0000;

        // Reset state
        cyc(1'b1, 1'b1, 1'b1, 16'hFFFF);
        chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        rst_n_in = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        chk4("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame table: load 16'hA5C3 at row 0, rd high throughout
        tbl[0] = '{ld:1'b1, rd:1'b1, en:1'b1, d:16'hA5C3, ser:1'b0, val:1'b0, busy:1'b0, done:1'b0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{ld:1'b0, rd:1'b1, en:1'b1, d:16'h0000,
                       ser:basic_seq[i-1][0], val:1'b1, busy:1'b1, done:1'b0};
        tbl[17] = '{ld:1'b0, rd:1'b1, en:1'b1, d:16'h0000, ser:1'b0, val:1'b0, busy:1'b1, done:1'b1};
        tbl[18] = '{ld:1'b0, rd:1'b1, en:1'b1, d:16'h0000, ser:1'b0, val:1'b0, busy:1'b0, done:1'b0};
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].ld, tbl[i].rd, tbl[i].en, tbl[i].d);
            chk4($sformatf("basic[%0d]", i), tbl[i].ser, tbl[i].val, tbl[i].busy, tbl[i].done);
        end

        // Gapped reads: each bit held until consumed
        cyc(1'b1, 1'b0, 1'b1, 16'h8001);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 16'h0000);
            chk4($sformatf("gap_hold[%0d]", i), (i == 0 || i == 15), 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("gap_rd[%0d]", i), (i == 0 || i == 15), 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        chk4("gap_done", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        chk4("gap_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load while busy: loads at bits 3, 10 and in DONE are ignored
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            cyc((i == 3 || i == 10), 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("lwb_bit[%0d]", i), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b1, 16'h0000);
        chk4("lwb_done", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        chk4("lwb_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("lwb2_bit[%0d]", i), 1'b0, 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        chk4("lwb2_done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Enable freeze after bit 4 is presented
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 16'h00F0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("frz_pre[%0d]", i), 1'b0, 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000);
            chk4($sformatf("frz_hold[%0d]", i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 4; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("frz_post[%0d]", i), (i >= 4 && i <= 7), 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk4("frz_done", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk4("frz_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame at bit 7 (16'h1234 bit 7 = 0, bit 4 = 1)
        cyc(1'b1, 1'b0, 1'b1, 16'h1234);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk($sformatf("rst_pre[%0d].serial", i), int'(s_ser), (i == 2 || i == 4 || i == 5) ? 1 : 0);
        end
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        chk("rst_pre_busy", int'(s_busy), 1);
        w = 16'h0000;
        #2;
        rst_n_in = 1'b0;
        #1;
        s_ser = serial_out; s_val = valid_out; s_busy = busy_out; s_done = done_out;
        chk4("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("rst_after[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b1, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("rst_new[%0d]", i), (i == 0), 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        chk4("rst_new_done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back frames at minimum spacing
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        w = 16'h3C00;
        cyc(1'b1, 1'b1, 1'b1, w);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("b2b_a[%0d]", i), w[i], 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        chk4("b2b_a_done", 1'b0, 1'b0, 1'b1, 1'b1);
        done_a = cyc_no;
        w = 16'hC000;
        cyc(1'b1, 1'b1, 1'b1, w);
        chk4("b2b_b_load", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000);
            chk4($sformatf("b2b_b[%0d]", i), w[i], 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        chk4("b2b_b_done", 1'b0, 1'b0, 1'b1, 1'b1);
        done_b = cyc_no;
        chk("b2b_spacing", done_b - done_a, 18);
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        chk4("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
